stack_op_sequencer: RTL and testbench

Controller that sequences all operations on the 16-entry LIFO stack and shares it between two requesters (A and B). It arbitrates round-robin, checks full/empty, drives the stack's push/pop strobes, and runs multi-cycle compound operations (ADD, DUP) so requesters issue one request and receive one ack. It sits between the switch/command front ends and the stack storage block, whose top-of-stack value feeds the 7-segment display path.

---
 rtl/stack_op_sequencer.sv | 180 ++++++++++++++++++
 tb/tb_stack_op_sequencer.sv | 337 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/stack_op_sequencer.sv
// stack_op_sequencer: shares a LIFO stack between two requesters, arbitrates
// round-robin, checks occupancy and sequences multi-cycle ops (ADD, DUP).
module stack_op_sequencer #(
    parameter int WIDTH = 6,
    parameter int DEPTH = 16,
    parameter int CW    = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_a,
    input  logic             req_b,
    input  logic [1:0]       op_a,
    input  logic [1:0]       op_b,
    input  logic [WIDTH-1:0] data_a,
    input  logic [WIDTH-1:0] data_b,
    output logic             ack_a,
    output logic             ack_b,
    output logic             err_a,
    output logic             err_b,
    output logic [WIDTH-1:0] rdata,
    output logic             busy,
    output logic             stk_push,
    output logic             stk_pop,
    output logic [WIDTH-1:0] stk_wdata,
    input  logic [WIDTH-1:0] stk_top,
    input  logic [CW-1:0]    stk_count
);

    localparam logic [1:0] OpPush = 2'b00;
    localparam logic [1:0] OpPop  = 2'b01;
    localparam logic [1:0] OpAdd  = 2'b10;
    localparam logic [1:0] OpDup  = 2'b11;

    localparam logic [CW-1:0] FullCount = CW'(DEPTH);
    localparam logic [CW-1:0] TwoCount  = CW'(2);

    typedef enum logic [2:0] {
        StIdle,
        StExec,
        StPop2,
        StPushr,
        StDone
    } state_t;

    state_t           state;
    logic             last_b;     // last grant went to B
    logic             gnt_b;      // current grant is B
    logic [1:0]       cur_op;
    logic             rej;        // current op rejected
    logic [WIDTH-1:0] opnd;
    logic [WIDTH-1:0] result;

    logic             grant_valid;
    logic             grant_b;
    logic [1:0]       sel_op;
    logic [WIDTH-1:0] sel_data;
    logic             legal;
    logic [WIDTH-1:0] sum;

    // Round-robin arbitration and legality check of the candidate op.
    always_comb begin
        grant_valid = req_a | req_b;
        if (req_a && req_b) begin
            grant_b = ~last_b;
        end else begin
            grant_b = req_b;
        end
        sel_op   = grant_b ? op_b : op_a;
        sel_data = grant_b ? data_b : data_a;
        legal    = 1'b0;
        unique case (sel_op)
            OpPush: legal = (stk_count < FullCount);
            OpPop:  legal = (stk_count != '0);
            OpAdd:  legal = (stk_count >= TwoCount);
            OpDup:  legal = (stk_count != '0) && (stk_count < FullCount);
        endcase
        sum = opnd + stk_top;
    end

    // Sequencer FSM. Outputs are registered, so the EXEC-cycle strobes are
    // decided on the grant edge; the stack is idle then, so count/top are stable.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= StIdle;
            last_b    <= 1'b1;
            gnt_b     <= 1'b0;
            cur_op    <= OpPush;
            rej       <= 1'b0;
            opnd      <= '0;
            result    <= '0;
            ack_a     <= 1'b0;
            ack_b     <= 1'b0;
            err_a     <= 1'b0;
            err_b     <= 1'b0;
            rdata     <= '0;
            busy      <= 1'b0;
            stk_push  <= 1'b0;
            stk_pop   <= 1'b0;
            stk_wdata <= '0;
        end else begin
            stk_push <= 1'b0;
            stk_pop  <= 1'b0;
            ack_a    <= 1'b0;
            ack_b    <= 1'b0;
            err_a    <= 1'b0;
            err_b    <= 1'b0;
            case (state)
                StIdle: begin
                    if (grant_valid) begin
                        gnt_b  <= grant_b;
                        last_b <= grant_b;
                        cur_op <= sel_op;
                        rej    <= ~legal;
                        busy   <= 1'b1;
                        state  <= StExec;
                        if (legal) begin
                            unique case (sel_op)
                                OpPush: begin
                                    stk_push  <= 1'b1;
                                    stk_wdata <= sel_data;
                                    result    <= sel_data;
                                end
                                OpPop: begin
                                    stk_pop <= 1'b1;
                                    result  <= stk_top;
                                end
                                OpAdd: begin
                                    stk_pop <= 1'b1;
                                    opnd    <= stk_top;
                                end
                                OpDup: begin
                                    stk_push  <= 1'b1;
                                    stk_wdata <= stk_top;
                                    result    <= stk_top;
                                end
                            endcase
                        end
                    end
                end
                StExec: begin
                    if (cur_op == OpAdd && !rej) begin
                        stk_pop <= 1'b1;
                        state   <= StPop2;
                    end else begin
                        ack_a <= ~gnt_b;
                        ack_b <= gnt_b;
                        err_a <= ~gnt_b & rej;
                        err_b <= gnt_b & rej;
                        if (!rej) begin
                            rdata <= result;
                        end
                        state <= StDone;
                    end
                end
                StPop2: begin
                    // stk_top now shows the second operand after the first pop.
                    result    <= sum;
                    stk_push  <= 1'b1;
                    stk_wdata <= sum;
                    state     <= StPushr;
                end
                StPushr: begin
                    ack_a <= ~gnt_b;
                    ack_b <= gnt_b;
                    rdata <= result;
                    state <= StDone;
                end
                StDone: begin
                    busy  <= 1'b0;
                    state <= StIdle;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_stack_op_sequencer.sv
// tb_stack_op_sequencer: directed scenarios against a behavioural stack model.
module tb_stack_op_sequencer;

    localparam logic [1:0] OpPush = 2'b00;
    localparam logic [1:0] OpPop  = 2'b01;
    localparam logic [1:0] OpAdd  = 2'b10;
    localparam logic [1:0] OpDup  = 2'b11;

    logic       clk = 1'b0;
    logic       rst;
    logic       req_a, req_b;
    logic [1:0] op_a, op_b;
    logic [5:0] data_a, data_b;
    logic       ack_a, ack_b, err_a, err_b;
    logic [5:0] rdata;
    logic       busy, stk_push, stk_pop;
    logic [5:0] stk_wdata;
    logic [5:0] stk_top;
    logic [4:0] stk_count;

    int checks = 0;
    int passed = 0;

    // run_op results
    int         r_lat;
    logic       r_err;
    logic [5:0] r_rd;
    logic [7:0] r_push, r_pop, r_busy;
    logic [5:0] r_wd;
    logic       r_stray;

    always #5 clk = ~clk;

    stack_op_sequencer dut (
        .clk(clk), .rst(rst),
        .req_a(req_a), .req_b(req_b),
        .op_a(op_a), .op_b(op_b),
        .data_a(data_a), .data_b(data_b),
        .ack_a(ack_a), .ack_b(ack_b),
        .err_a(err_a), .err_b(err_b),
        .rdata(rdata), .busy(busy),
        .stk_push(stk_push), .stk_pop(stk_pop),
        .stk_wdata(stk_wdata),
        .stk_top(stk_top), .stk_count(stk_count)
    );

    // Registered stack model: top/count reflect a strobe on the next cycle.
    logic [5:0] mem [16];
    logic [4:0] top_idx;
    always_ff @(posedge clk) begin
        if (rst) begin
            stk_count <= 5'd0;
        end else if (stk_push && stk_count < 5'd16) begin
            mem[stk_count[3:0]] <= stk_wdata;
            stk_count <= stk_count + 5'd1;
        end else if (stk_pop && stk_count != 5'd0) begin
            stk_count <= stk_count - 5'd1;
        end
    end
    always_comb begin
        top_idx = stk_count - 5'd1;
        stk_top = (stk_count == 5'd0) ? 6'd0 : mem[top_idx[3:0]];
    end

    task automatic do_reset();
        rst = 1'b1; req_a = 1'b0; req_b = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Issues one request and records strobes/busy per cycle (n = cycles after grant).
    task automatic run_op(input logic use_b, input logic [1:0] op, input logic [5:0] data);
        int k;
        r_lat = -1; r_err = 1'b0; r_rd = '0; r_push = '0; r_pop = '0; r_busy = '0;
        r_wd = '0; r_stray = 1'b0;
        @(negedge clk);
        if (use_b) begin req_b = 1'b1; op_b = op; data_b = data; end
        else       begin req_a = 1'b1; op_a = op; data_a = data; end
        for (int n = 1; n < 8 && r_lat < 0; n++) begin
            @(negedge clk);
            r_push[n[2:0]] = stk_push;
            r_pop[n[2:0]]  = stk_pop;
            r_busy[n[2:0]] = busy;
            if (stk_push) r_wd = stk_wdata;
            if (use_b ? (ack_a | err_a) : (ack_b | err_b)) r_stray = 1'b1;
            if (use_b ? ack_b : ack_a) begin
                r_lat = n;
                r_err = use_b ? err_b : err_a;
                r_rd  = rdata;
                req_a = 1'b0; req_b = 1'b0;
            end
        end
        req_a = 1'b0; req_b = 1'b0;
        @(negedge clk);
        if (r_lat >= 0) begin
            k = r_lat + 1;
            r_busy[k[2:0]] = busy;
        end
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if ({ack_a, ack_b, err_a, err_b, busy, stk_push, stk_pop} !== 7'b0)
            $display("FAIL reset_ctrl: got %b want 0000000",
                     {ack_a, ack_b, err_a, err_b, busy, stk_push, stk_pop});
        else passed++;
        checks++;
        if ({stk_wdata, rdata} !== 12'd0)
            $display("FAIL reset_data: got wdata=%0d rdata=%0d want 0/0", stk_wdata, rdata);
        else passed++;
    endtask

    task automatic test_push();
        do_reset();
        run_op(1'b0, OpPush, 6'd17);
        checks++;
        if (r_lat !== 2) $display("FAIL push_latency: got %0d want 2", r_lat); else passed++;
        checks++;
        if (r_push !== 8'b0000_0010 || r_pop !== 8'b0)
            $display("FAIL push_strobes: got push=%b pop=%b want 00000010/0", r_push, r_pop);
        else passed++;
        checks++;
        if (r_wd !== 6'd17) $display("FAIL push_wdata: got %0d want 17", r_wd); else passed++;
        checks++;
        if (r_err !== 1'b0 || r_rd !== 6'd17 || r_stray !== 1'b0)
            $display("FAIL push_ack: got err=%b rdata=%0d stray=%b want 0/17/0",
                     r_err, r_rd, r_stray);
        else passed++;
        checks++;
        if (r_busy !== 8'b0000_0110)
            $display("FAIL push_busy: got %b want 00000110", r_busy);
        else passed++;
    endtask

    task automatic test_add();
        do_reset();
        run_op(1'b0, OpPush, 6'd5);
        run_op(1'b0, OpPush, 6'd9);
        run_op(1'b1, OpAdd, 6'd0);
        checks++;
        if (r_lat !== 4) $display("FAIL add_latency: got %0d want 4", r_lat); else passed++;
        checks++;
        if (r_pop !== 8'b0000_0110 || r_push !== 8'b0000_1000)
            $display("FAIL add_strobes: got pop=%b push=%b want 00000110/00001000",
                     r_pop, r_push);
        else passed++;
        checks++;
        if (r_wd !== 6'd14 || r_rd !== 6'd14 || r_err !== 1'b0 || r_stray !== 1'b0)
            $display("FAIL add_result: got wdata=%0d rdata=%0d err=%b stray=%b want 14/14/0/0",
                     r_wd, r_rd, r_err, r_stray);
        else passed++;
        checks++;
        if (stk_count !== 5'd1 || r_busy !== 8'b0001_1110)
            $display("FAIL add_count_busy: got count=%0d busy=%b want 1/00011110",
                     stk_count, r_busy);
        else passed++;
        // 40 + 30 wraps to 6
        run_op(1'b0, OpPush, 6'd40);
        run_op(1'b0, OpPush, 6'd30);
        run_op(1'b0, OpAdd, 6'd0);
        checks++;
        if (r_rd !== 6'd6 || stk_top !== 6'd6 || stk_count !== 5'd2)
            $display("FAIL add_wrap: got rdata=%0d top=%0d count=%0d want 6/6/2",
                     r_rd, stk_top, stk_count);
        else passed++;
    endtask

    task automatic test_empty();
        do_reset();
        run_op(1'b0, OpPush, 6'd17);
        run_op(1'b0, OpPop, 6'd0);
        checks++;
        if (r_err !== 1'b0 || r_rd !== 6'd17 || r_pop !== 8'b0000_0010 || stk_count !== 5'd0)
            $display("FAIL pop_ok: got err=%b rdata=%0d pop=%b count=%0d want 0/17/00000010/0",
                     r_err, r_rd, r_pop, stk_count);
        else passed++;
        run_op(1'b0, OpPop, 6'd0);
        checks++;
        if (r_lat !== 2 || r_err !== 1'b1 || r_rd !== 6'd17)
            $display("FAIL pop_empty: got lat=%0d err=%b rdata=%0d want 2/1/17",
                     r_lat, r_err, r_rd);
        else passed++;
        checks++;
        if (r_push !== 8'b0 || r_pop !== 8'b0)
            $display("FAIL pop_empty_strobes: got push=%b pop=%b want 0/0", r_push, r_pop);
        else passed++;
        run_op(1'b0, OpAdd, 6'd0);
        checks++;
        if (r_lat !== 2 || r_err !== 1'b1 || r_rd !== 6'd17 || r_push !== 8'b0 || r_pop !== 8'b0)
            $display("FAIL add_empty: got lat=%0d err=%b rdata=%0d push=%b pop=%b want 2/1/17/0/0",
                     r_lat, r_err, r_rd, r_push, r_pop);
        else passed++;
    endtask

    task automatic test_full();
        int bad;
        bad = 0;
        do_reset();
        for (int i = 0; i < 16; i++) begin
            run_op(1'b0, OpPush, 6'(i + 1));
            if (r_lat != 2 || r_err != 1'b0) bad++;
        end
        checks++;
        if (bad !== 0 || stk_count !== 5'd16)
            $display("FAIL fill: got bad=%0d count=%0d want 0/16", bad, stk_count);
        else passed++;
        run_op(1'b1, OpPush, 6'd3);
        checks++;
        if (r_err !== 1'b1 || r_rd !== 6'd16 || r_push !== 8'b0 || stk_count !== 5'd16)
            $display("FAIL push_full: got err=%b rdata=%0d push=%b count=%0d want 1/16/0/16",
                     r_err, r_rd, r_push, stk_count);
        else passed++;
        run_op(1'b1, OpDup, 6'd0);
        checks++;
        if (r_err !== 1'b1 || r_push !== 8'b0 || r_stray !== 1'b0)
            $display("FAIL dup_full: got err=%b push=%b stray=%b want 1/0/0",
                     r_err, r_push, r_stray);
        else passed++;
        run_op(1'b1, OpPop, 6'd0);
        checks++;
        if (r_err !== 1'b0 || r_rd !== 6'd16 || stk_count !== 5'd15)
            $display("FAIL pop_full: got err=%b rdata=%0d count=%0d want 0/16/15",
                     r_err, r_rd, stk_count);
        else passed++;
        run_op(1'b1, OpDup, 6'd0);
        checks++;
        if (r_err !== 1'b0 || r_wd !== 6'd15 || r_rd !== 6'd15 || stk_count !== 5'd16)
            $display("FAIL dup_ok: got err=%b wdata=%0d rdata=%0d count=%0d want 0/15/15/16",
                     r_err, r_wd, r_rd, stk_count);
        else passed++;
    endtask

    task automatic test_round_robin();
        int acks, cool_a, cool_b, rem_a, rem_b, rd_bad, first_cyc, last_cyc;
        logic [7:0] who;
        logic both;
        logic [5:0] top1;
        acks = 0; cool_a = 0; cool_b = 0; rem_a = 4; rem_b = 4; rd_bad = 0;
        first_cyc = -1; last_cyc = -1; who = '0; both = 1'b0; top1 = '0;
        do_reset();
        @(negedge clk);
        req_a = 1'b1; op_a = OpPush; data_a = 6'd1;
        req_b = 1'b1; op_b = OpPush; data_b = 6'd2;
        for (int cyc = 0; cyc < 100 && acks < 8; cyc++) begin
            @(negedge clk);
            if (ack_a && ack_b) both = 1'b1;
            if (ack_a) begin
                who[acks[2:0]] = 1'b0;
                if (rdata !== 6'd1) rd_bad++;
                acks++; rem_a--; cool_a = 2; req_a = 1'b0;
            end else if (cool_a > 0) begin
                cool_a--;
                if (cool_a == 0 && rem_a > 0) req_a = 1'b1;
            end
            if (ack_b) begin
                who[acks[2:0]] = 1'b1;
                if (rdata !== 6'd2) rd_bad++;
                acks++; rem_b--; cool_b = 2; req_b = 1'b0;
            end else if (cool_b > 0) begin
                cool_b--;
                if (cool_b == 0 && rem_b > 0) req_b = 1'b1;
            end
            if (ack_a || ack_b) begin
                if (first_cyc < 0) first_cyc = cyc;
                last_cyc = cyc;
                if (acks == 2) top1 = stk_top;
            end
        end
        req_a = 1'b0; req_b = 1'b0;
        checks++;
        if (acks !== 8 || who !== 8'b1010_1010 || both !== 1'b0)
            $display("FAIL rr_order: got acks=%0d order=%b both=%b want 8/10101010/0",
                     acks, who, both);
        else passed++;
        checks++;
        if (top1 !== 6'd2 || rd_bad !== 0)
            $display("FAIL rr_data: got top=%0d rdata_bad=%0d want 2/0", top1, rd_bad);
        else passed++;
        checks++;
        if (last_cyc - first_cyc !== 21 || stk_count !== 5'd8)
            $display("FAIL rr_interval: got span=%0d count=%0d want 21/8",
                     last_cyc - first_cyc, stk_count);
        else passed++;
    endtask

    task automatic test_reset_mid();
        logic early_ack;
        early_ack = 1'b0;
        do_reset();
        run_op(1'b0, OpPush, 6'd5);
        run_op(1'b0, OpPush, 6'd9);
        @(negedge clk);
        req_b = 1'b1; op_b = OpAdd; data_b = 6'd0;
        @(negedge clk);
        if (ack_a || ack_b) early_ack = 1'b1;
        @(negedge clk);
        if (ack_a || ack_b) early_ack = 1'b1;
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if (early_ack !== 1'b0 ||
            {ack_a, ack_b, err_a, err_b, busy, stk_push, stk_pop} !== 7'b0)
            $display("FAIL midrst_ctrl: got early=%b ctrl=%b want 0/0000000", early_ack,
                     {ack_a, ack_b, err_a, err_b, busy, stk_push, stk_pop});
        else passed++;
        checks++;
        if (rdata !== 6'd0 || stk_wdata !== 6'd0)
            $display("FAIL midrst_data: got rdata=%0d wdata=%0d want 0/0", rdata, stk_wdata);
        else passed++;
        rst = 1'b0; req_b = 1'b0;
        run_op(1'b0, OpPush, 6'd7);
        checks++;
        if (r_lat !== 2 || r_err !== 1'b0 || r_rd !== 6'd7 || stk_count !== 5'd1)
            $display("FAIL midrst_push: got lat=%0d err=%b rdata=%0d count=%0d want 2/0/7/1",
                     r_lat, r_err, r_rd, stk_count);
        else passed++;
    endtask

    initial begin
        rst = 1'b1;
        req_a = 1'b0; req_b = 1'b0;
        op_a = OpPush; op_b = OpPush;
        data_a = '0; data_b = '0;
        test_reset();
        test_push();
        test_add();
        test_empty();
        test_full();
        test_round_robin();
        test_reset_mid();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
